// File: rtl/board_pkg.sv
// Shared widths, cell encoding and arbiter state type for the board RAM arbiter.
package board_pkg;

    localparam int BOARD_ADDR_W = 6;
    localparam int CELL_W       = 2;

    typedef enum logic [CELL_W-1:0] {
        EMPTY = 2'd0,
        BLACK = 2'd1,
        WHITE = 2'd2
    } cell_t;

    typedef enum logic {
        ARB      = 1'b0,
        CLR_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/board_arb_pick.sv
// Two-way move/display picker. Fixed move-first priority by default;
// alternating (last-served pointer) when BOARD_ARB_RR_EN is defined.
module board_arb_pick
    import board_pkg::*;
(
`ifdef BOARD_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en_i,
    input  logic mv_req_i,
    input  logic disp_req_i,
    output logic mv_gnt_o,
    output logic disp_gnt_o
);

`ifdef BOARD_ARB_RR_EN
    // fav_disp_q = 1 means display wins the next contested cycle
    logic fav_disp_q, fav_disp_d;

    always_comb begin
        mv_gnt_o   = en_i & mv_req_i & ~(disp_req_i & fav_disp_q);
        disp_gnt_o = en_i & disp_req_i & ~(mv_req_i & ~fav_disp_q);
        fav_disp_d = fav_disp_q;
        if (mv_gnt_o) begin
            fav_disp_d = 1'b1;
        end else if (disp_gnt_o) begin
            fav_disp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fav_disp_q <= 1'b0;
        end else begin
            fav_disp_q <= fav_disp_d;
        end
    end
`else
    always_comb begin
        mv_gnt_o   = en_i & mv_req_i;
        disp_gnt_o = en_i & disp_req_i & ~mv_req_i;
    end
`endif

endmodule

// File: rtl/board_ram_arbiter.sv
// Single-port board RAM arbiter: clear engine locks the port, move and display share it per cycle.
// Build option: BOARD_ARB_RR_EN selects round-robin move/display picking.
module board_ram_arbiter
    import board_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    clr_gnt,
    input  logic                    clr_we,
    input  logic [BOARD_ADDR_W-1:0] clr_addr,
    input  logic [CELL_W-1:0]       clr_data,
    input  logic                    mv_req,
    output logic                    mv_gnt,
    input  logic                    mv_we,
    input  logic [BOARD_ADDR_W-1:0] mv_addr,
    input  logic [CELL_W-1:0]       mv_wdata,
    input  logic                    disp_req,
    output logic                    disp_gnt,
    input  logic [BOARD_ADDR_W-1:0] disp_addr,
    output logic                    ram_we,
    output logic [BOARD_ADDR_W-1:0] ram_addr,
    output logic [CELL_W-1:0]       ram_wdata,
    input  logic [CELL_W-1:0]       ram_rdata,
    output logic [CELL_W-1:0]       rd_data,
    output logic                    mv_rvalid,
    output logic                    disp_rvalid,
    output logic                    busy
);

    arb_state_t state_q, state_d;
    logic       pick_en;
    logic       mv_rvalid_q, mv_rvalid_d;
    logic       disp_rvalid_q, disp_rvalid_d;

    always_comb begin
        state_d = state_q;
        clr_gnt = 1'b0;
        pick_en = 1'b0;
        case (state_q)
            ARB: begin
                if (clr_req) begin
                    clr_gnt = 1'b1;
                    state_d = CLR_LOCK;
                end else begin
                    pick_en = 1'b1;
                end
            end
            CLR_LOCK: begin
                clr_gnt = clr_req;
                if (!clr_req) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    board_arb_pick u_pick (
`ifdef BOARD_ARB_RR_EN
        .clk        (clk),
        .rst_n      (rst_n),
`endif
        .en_i       (pick_en),
        .mv_req_i   (mv_req),
        .disp_req_i (disp_req),
        .mv_gnt_o   (mv_gnt),
        .disp_gnt_o (disp_gnt)
    );

    // Idle port drives all zeros so the RAM never sees a stray write
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (clr_gnt) begin
            ram_we    = clr_we;
            ram_addr  = clr_addr;
            ram_wdata = clr_data;
        end else if (mv_gnt) begin
            ram_we    = mv_we;
            ram_addr  = mv_addr;
            ram_wdata = mv_wdata;
        end else if (disp_gnt) begin
            ram_addr  = disp_addr;
        end
    end

    assign mv_rvalid_d   = mv_gnt & ~mv_we;
    assign disp_rvalid_d = disp_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB;
            mv_rvalid_q   <= 1'b0;
            disp_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mv_rvalid_q   <= mv_rvalid_d;
            disp_rvalid_q <= disp_rvalid_d;
        end
    end

    assign busy        = (state_q == CLR_LOCK);
    assign mv_rvalid   = mv_rvalid_q;
    assign disp_rvalid = disp_rvalid_q;
    assign rd_data     = ram_rdata;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a rule-level model checked every negedge.
module tb_board_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_req, clr_we, mv_req, mv_we, disp_req;
    logic [5:0] clr_addr, mv_addr, disp_addr;
    logic [1:0] clr_data, mv_wdata;
    logic [1:0] ram_rdata;
    logic       clr_gnt, mv_gnt, disp_gnt, ram_we, mv_rvalid, disp_rvalid, busy;
    logic [5:0] ram_addr;
    logic [1:0] ram_wdata, rd_data;

    int total = 0;
    int bad   = 0;

    board_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .clr_req(clr_req), .clr_gnt(clr_gnt), .clr_we(clr_we), .clr_addr(clr_addr), .clr_data(clr_data),
        .mv_req(mv_req), .mv_gnt(mv_gnt), .mv_we(mv_we), .mv_addr(mv_addr), .mv_wdata(mv_wdata),
        .disp_req(disp_req), .disp_gnt(disp_gnt), .disp_addr(disp_addr),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rd_data(rd_data), .mv_rvalid(mv_rvalid), .disp_rvalid(disp_rvalid), .busy(busy)
    );

    always #10 clk = ~clk;

    // Behavioural RAM: read data appears one cycle after the address
    logic [1:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 2'd3;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the clear owns the port in the cycle clr_req is high and,
    // once it has started, in every later cycle until one cycle after it drops.
    bit m_lock, m_fav_disp, m_mv_rv, m_disp_rv;
    bit e_mv, e_disp, e_we, contest, turn_disp;
    logic [5:0] e_addr;
    logic [1:0] e_wd;

    always_comb begin
        contest = !m_lock && !clr_req;
`ifdef BOARD_ARB_RR_EN
        turn_disp = m_fav_disp;
`else
        turn_disp = 1'b0;
`endif
        e_mv   = contest && mv_req && !(disp_req && turn_disp);
        e_disp = contest && disp_req && !e_mv;
        e_we = 1'b0; e_addr = 6'd0; e_wd = 2'd0;
        if (clr_req) begin
            e_we = clr_we; e_addr = clr_addr; e_wd = clr_data;
        end else if (e_mv) begin
            e_we = mv_we; e_addr = mv_addr; e_wd = mv_wdata;
        end else if (e_disp) begin
            e_addr = disp_addr;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lock <= 1'b0; m_fav_disp <= 1'b0; m_mv_rv <= 1'b0; m_disp_rv <= 1'b0;
        end else begin
            m_lock    <= clr_req;
            m_mv_rv   <= e_mv && !mv_we;
            m_disp_rv <= e_disp;
            if (e_mv) m_fav_disp <= 1'b1;
            else if (e_disp) m_fav_disp <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("m_clr_gnt", {7'd0, clr_gnt}, {7'd0, clr_req});
        chk("m_mv_gnt", {7'd0, mv_gnt}, {7'd0, e_mv});
        chk("m_disp_gnt", {7'd0, disp_gnt}, {7'd0, e_disp});
        chk("m_ram_port", {ram_we, ram_addr, 1'b0}, {e_we, e_addr, 1'b0});
        chk("m_ram_wdata", {6'd0, ram_wdata}, {6'd0, e_wd});
        chk("m_busy", {7'd0, busy}, {7'd0, m_lock});
        chk("m_rvalid", {6'd0, mv_rvalid, disp_rvalid}, {6'd0, m_mv_rv, m_disp_rv});
        if (mv_rvalid || disp_rvalid) chk("m_rd_data", {6'd0, rd_data}, {6'd0, ram_rdata});
    end

    task automatic idle();
        clr_req = 0; clr_we = 0; clr_addr = 0; clr_data = 0;
        mv_req = 0; mv_we = 0; mv_addr = 0; mv_wdata = 0;
        disp_req = 0; disp_addr = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    logic [1:0] exp_seq [4];
    logic [1:0] got;
    int n_wr, n_mv, n_busy;

    initial begin
`ifdef BOARD_ARB_RR_EN
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1; exp_seq[3] = 2'd2;
`else
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd1; exp_seq[2] = 2'd1; exp_seq[3] = 2'd1;
`endif
        idle();
        rst_n = 0;
        #1;
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_rvalid", {6'd0, mv_rvalid, disp_rvalid}, 8'd0);
        chk("rst_gnt", {5'd0, clr_gnt, mv_gnt, disp_gnt}, 8'd0);
        #4 rst_n = 1;

        // contested move/display for 4 cycles
        for (int i = 0; i < 4; i++) begin
            cyc(); idle(); mv_req = 1; disp_req = 1; mv_addr = 6'd10; disp_addr = 6'd20;
            #1;
            got = {disp_gnt, mv_gnt};
            chk("contest_seq", {6'd0, got}, {6'd0, exp_seq[i]});
        end

        // move write then read of cell 5
        cyc(); idle(); mv_req = 1; mv_we = 1; mv_addr = 6'd5; mv_wdata = 2'd1;
        #1;
        chk("mv_wr_port", {ram_we, ram_addr, 1'b0}, {1'b1, 6'd5, 1'b0});
        chk("mv_wr_data", {6'd0, ram_wdata}, 8'd1);
        cyc(); idle(); mv_req = 1; mv_addr = 6'd5;
        #1;
        chk("mv_rd_gnt", {6'd0, mv_gnt, ram_we}, 8'd2);
        cyc(); idle();
        #1;
        chk("mv_rd_rvalid", {6'd0, mv_rvalid, disp_rvalid}, 8'd2);
        chk("mv_rd_data", {6'd0, rd_data}, 8'd1);

        // display read of cell 63
        cyc(); idle(); disp_req = 1; disp_addr = 6'd63;
        #1;
        chk("disp_port", {disp_gnt, ram_we, ram_addr}, {1'b1, 1'b0, 6'd63});
        cyc(); idle();
        #1;
        chk("disp_rvalid", {6'd0, mv_rvalid, disp_rvalid}, 8'd1);
        chk("disp_rd_data", {6'd0, rd_data}, 8'd3);

        // all three requesters rise together
        cyc(); idle(); clr_req = 1; mv_req = 1; disp_req = 1;
        #1;
        chk("tri_gnt", {5'd0, clr_gnt, mv_gnt, disp_gnt}, 8'd4);
        chk("tri_busy0", {7'd0, busy}, 8'd0);
        cyc(); idle();
        #1;
        chk("tri_busy1", {7'd0, busy}, 8'd1);
        cyc();

        // full 64-cell clear with move held off
        n_wr = 0; n_mv = 0; n_busy = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(); idle(); clr_req = 1; clr_we = 1; clr_addr = 6'(i); mv_req = 1; mv_addr = 6'd7;
            #1;
            if (ram_we === 1'b1 && ram_wdata === 2'd0 && ram_addr === 6'(i)) n_wr++;
            if (mv_gnt !== 1'b0) n_mv++;
            if (busy === 1'b1) n_busy++;
        end
        chk("clr_writes", 8'(n_wr), 8'd64);
        chk("clr_mv_held", 8'(n_mv), 8'd0);
        chk("clr_busy_cycles", 8'(n_busy), 8'd63);
        cyc(); clr_req = 0; clr_we = 0;
        #1;
        chk("clr_tail", {6'd0, mv_gnt, busy}, 8'd1);
        cyc();
        #1;
        chk("clr_release", {6'd0, mv_gnt, busy}, 8'd2);
        cyc(); idle();
        #1;
        chk("clr_mv_rvalid", {7'd0, mv_rvalid}, 8'd1);
        chk("clr_rd_data", {6'd0, rd_data}, 8'd0);

        // reset in the middle of a clear
        for (int i = 0; i <= 30; i++) begin
            cyc(); idle(); clr_req = 1; clr_we = 1; clr_addr = 6'(i);
        end
        #2 rst_n = 0;
        #1;
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_rvalid", {6'd0, mv_rvalid, disp_rvalid}, 8'd0);
        idle(); mv_req = 1; mv_addr = 6'd5;
        #1 rst_n = 1;
        #1;
        chk("post_rst_mv_gnt", {6'd0, mv_gnt, busy}, 8'd2);
        cyc(); idle();
        #1;
        chk("post_rst_rvalid", {6'd0, mv_rvalid, rd_data}, {5'd0, 1'b1, 2'd0});
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_ram_arbiter.md
BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 clr_req  in  1  clear engine requests board RAM; held high for the whole clear burst.
REQ-004 clr_gnt  out  1  clear engine owns RAM port this cycle.
REQ-005 clr_we / clr_addr / clr_data  in  1/6/2  clear engine write strobe, cell address, cell value.
REQ-006 mv_req  in  1  move logic requests one access this cycle.
REQ-007 mv_gnt  out  1  move access accepted this cycle.
REQ-008 mv_we / mv_addr / mv_wdata  in  1/6/2  move write strobe (0 = read), address, write value.
REQ-009 disp_req  in  1  display scanner requests one read this cycle.
REQ-010 disp_gnt  out  1  display read accepted this cycle.
REQ-011 disp_addr  in  6  display read address.
REQ-012 ram_we / ram_addr / ram_wdata  out  1/6/2  single RAM port.
REQ-013 ram_rdata  in  2  RAM read data, valid one cycle after the address.
REQ-014 rd_data  out  2  read data return, equals ram_rdata.
REQ-015 mv_rvalid / disp_rvalid  out  1/1  rd_data belongs to move / display read granted the previous cycle.
REQ-016 busy  out  1  board clear in progress (state CLR_LOCK).

Function
REQ-017 The block SHALL implement two states: ARB (per-cycle arbitration) and CLR_LOCK (clear owns the port).
REQ-018 ARB, clr_req=1: clr_gnt=1 in the same cycle, mv_gnt=disp_gnt=0, next state CLR_LOCK.
REQ-019 CLR_LOCK: clr_gnt=clr_req, mv_gnt=disp_gnt=0; return to ARB in the cycle after clr_req=0.
REQ-020 ARB, clr_req=0: at most one of mv_gnt/disp_gnt asserted, per REQ-029; a grant requires its req in the same cycle.
REQ-021 Grants SHALL be combinational from req and state; no grant without req; one access per grant cycle.
REQ-022 RAM port SHALL mux the granted requester's signals; with no grant, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-023 Display accesses SHALL always drive ram_we=0.
REQ-024 mv_rvalid SHALL assert exactly one cycle after a cycle with mv_gnt=1 and mv_we=0; disp_rvalid one cycle after disp_gnt=1.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 Ungranted requesters retry by holding req; the arbiter stores no pending requests.

Reset
REQ-027 rst_n=0 SHALL force state ARB, mv_rvalid=disp_rvalid=0, busy=0 and the round-robin pointer to favour move, immediately and asynchronously.
REQ-028 Reset during CLR_LOCK SHALL abandon the clear; after reset, a new clr_req restarts arbitration from ARB.

Configuration
REQ-029 Macro BOARD_ARB_RR_EN: defined -> move and display alternate when both request in ARB, with a 1-bit last-served pointer updated on each mv/disp grant; undefined -> fixed priority, move always beats display, and no pointer is instantiated.

Structure
REQ-030 Package board_pkg SHALL hold BOARD_ADDR_W=6, CELL_W=2, the cell enum (EMPTY=0, BLACK=1, WHITE=2) and the arbiter state typedef.
REQ-031 A sub-module board_arb_pick SHALL hold the 2-way move/display picker: fixed or round-robin per REQ-029.

Verification
REQ-032 clr_req high for 64 cycles, addr 0..63, data 0; mv_req held high throughout -> mv_gnt=0 for all 64 cycles, busy=1, 64 writes of 0 seen on the RAM port; mv_gnt=1 in the cycle after clr_req falls.
REQ-033 mv write addr 5, data BLACK, then mv read addr 5 -> ram_we=1 / ram_addr=5 / ram_wdata=1, then mv_rvalid=1 with rd_data=1 one cycle after the read grant.
REQ-034 mv_req and disp_req both held high for 4 cycles -> RR_EN: grants M,D,M,D; without RR_EN: M,M,M,M, disp_gnt=0.
REQ-035 clr_req, mv_req and disp_req rise in the same cycle -> only clr_gnt=1; state CLR_LOCK next cycle.
REQ-036 rst_n low mid-clear at addr 30 -> busy=0 and rvalids=0 immediately; after release, mv_req is granted in the same cycle.
REQ-037 disp read addr 63, no other requests -> ram_addr=63, ram_we=0, disp_rvalid=1 next cycle, mv_rvalid=0.
